// File: rtl/game_pkg.sv
// Shared types and constants for the Minesweeper game sequencer:
// state encoding, difficulty selection and the per-difficulty board table.
package game_pkg;

    typedef enum logic [2:0] {
        MENU = 3'd0,
        GEN  = 3'd1,
        PLAY = 3'd2,
        WIN  = 3'd3,
        LOSE = 3'd4
    } game_state_t;

    typedef enum logic [1:0] {
        DIFF_EASY   = 2'd0,
        DIFF_MEDIUM = 2'd1,
        DIFF_HARD   = 2'd2
    } diff_t;

    // Indexed by diff_t value: easy, medium, hard.
    localparam logic [4:0] DIFF_SIZE  [3] = '{5'd8, 5'd16, 5'd24};
    localparam logic [6:0] DIFF_MINES [3] = '{7'd10, 7'd40, 7'd99};

    localparam int FRAMES_PER_SEC_DEF = 60;
    localparam int GEN_TIMEOUT_DEF    = 4;
    localparam int SEC_MAX_DEF        = 999;

    // Lowest set bit wins: easy > medium > hard.
    function automatic diff_t btn_to_diff(input logic [2:0] btn);
        if (btn[0])      return DIFF_EASY;
        else if (btn[1]) return DIFF_MEDIUM;
        else             return DIFF_HARD;
    endfunction

    function automatic logic [4:0] diff_size(input diff_t d);
        if (d == DIFF_HARD)        return DIFF_SIZE[2];
        else if (d == DIFF_MEDIUM) return DIFF_SIZE[1];
        else                       return DIFF_SIZE[0];
    endfunction

    function automatic logic [6:0] diff_mines(input diff_t d);
        if (d == DIFF_HARD)        return DIFF_MINES[2];
        else if (d == DIFF_MEDIUM) return DIFF_MINES[1];
        else                       return DIFF_MINES[0];
    endfunction

endpackage

// File: rtl/game_timer.sv
// Elapsed-play timer: divides frame_start pulses down to seconds and
// saturates the seconds count at SEC_MAX.
module game_timer
    import game_pkg::*;
#(
    parameter int FRAMES_PER_SEC = FRAMES_PER_SEC_DEF,
    parameter int SEC_MAX        = SEC_MAX_DEF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clear_i,
    input  logic       run_i,
    input  logic       frame_start_i,
    output logic [9:0] seconds_o
);

    localparam int DW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(FRAMES_PER_SEC - 1);
    localparam logic [9:0]    SEC_SAT  = 10'(SEC_MAX);

    logic [DW-1:0] frame_div_q, frame_div_d;
    logic [9:0]    seconds_q, seconds_d;

    always_comb begin
        frame_div_d = frame_div_q;
        seconds_d   = seconds_q;
        if (clear_i) begin
            frame_div_d = '0;
            seconds_d   = '0;
        end else if (run_i && frame_start_i) begin
            if (frame_div_q == DIV_LAST) begin
                frame_div_d = '0;
                if (seconds_q != SEC_SAT) begin
                    seconds_d = seconds_q + 10'd1;
                end
            end else begin
                frame_div_d = frame_div_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_div_q <= '0;
            seconds_q   <= '0;
        end else begin
            frame_div_q <= frame_div_d;
            seconds_q   <= seconds_d;
        end
    end

    assign seconds_o = seconds_q;

endmodule

// File: rtl/game_ctl.sv
// Game sequencer: difficulty capture, frame-aligned config load, generator
// handshake with timeout, play/win/lose tracking and the elapsed-time timer.
module game_ctl
    import game_pkg::*;
#(
    parameter int FRAMES_PER_SEC = FRAMES_PER_SEC_DEF,
    parameter int GEN_TIMEOUT    = GEN_TIMEOUT_DEF,
    parameter int SEC_MAX        = SEC_MAX_DEF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [2:0] btn_pulse_i,
    input  logic       frame_start_i,
    input  logic       gen_done_i,
    input  logic       mine_hit_i,
    input  logic [9:0] revealed_cnt_i,
    output logic       gen_start_o,
    output logic [4:0] board_size_o,
    output logic [6:0] mine_count_o,
    output logic [2:0] game_state_o,
    output logic       play_en_o,
    output logic [9:0] seconds_o,
    output logic       gen_err_o
);

    localparam int GW = (GEN_TIMEOUT > 1) ? $clog2(GEN_TIMEOUT + 1) : 1;
    localparam logic [GW-1:0] GEN_LAST = GW'(GEN_TIMEOUT - 1);

    game_state_t   state_q, state_d;
    diff_t         pend_diff_q, pend_diff_d;
    logic          pend_vld_q, pend_vld_d;
    logic [GW-1:0] gen_frames_q, gen_frames_d;
    logic [4:0]    size_q, size_d;
    logic [6:0]    mines_q, mines_d;
    logic          gen_start_q, gen_start_d;
    logic          play_en_q, play_en_d;
    logic          gen_err_q, gen_err_d;
    logic          timer_clear;
    logic          timer_run;
    logic [9:0]    win_target;
    logic          win_hit;

    // Safe cells on the current board; 24*24 = 576 still fits in 10 bits.
    assign win_target = ({5'd0, size_q} * {5'd0, size_q}) - {3'd0, mines_q};
    assign win_hit    = (revealed_cnt_i == win_target);

    always_comb begin
        state_d      = state_q;
        pend_diff_d  = pend_diff_q;
        pend_vld_d   = pend_vld_q;
        gen_frames_d = gen_frames_q;
        size_d       = size_q;
        mines_d      = mines_q;
        gen_err_d    = gen_err_q;
        gen_start_d  = 1'b0;
        timer_clear  = 1'b0;

        case (state_q)
            MENU: begin
                // A press in the same cycle as the frame boundary still counts.
                if (|btn_pulse_i) begin
                    pend_vld_d  = 1'b1;
                    pend_diff_d = btn_to_diff(btn_pulse_i);
                end
                if (frame_start_i && pend_vld_d) begin
                    size_d       = diff_size(pend_diff_d);
                    mines_d      = diff_mines(pend_diff_d);
                    gen_err_d    = 1'b0;
                    gen_start_d  = 1'b1;
                    timer_clear  = 1'b1;
                    pend_vld_d   = 1'b0;
                    gen_frames_d = '0;
                    state_d      = GEN;
                end
            end
            GEN: begin
                if (gen_done_i) begin
                    timer_clear = 1'b1;
                    state_d     = PLAY;
                end else if (frame_start_i) begin
                    if (gen_frames_q == GEN_LAST) begin
                        gen_err_d = 1'b1;
                        state_d   = MENU;
                    end else begin
                        gen_frames_d = gen_frames_q + GW'(1);
                    end
                end
            end
            PLAY: begin
                if (mine_hit_i) begin
                    state_d = LOSE;
                end else if (win_hit) begin
                    state_d = WIN;
                end
            end
            WIN, LOSE: begin
                if (|btn_pulse_i) begin
                    state_d = MENU;
                end
            end
            default: state_d = MENU;
        endcase

        play_en_d = (state_d == PLAY);
    end

    // The timer only advances while play continues through this cycle.
    assign timer_run = (state_q == PLAY) && (state_d == PLAY);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= MENU;
            pend_diff_q  <= DIFF_EASY;
            pend_vld_q   <= 1'b0;
            gen_frames_q <= '0;
            size_q       <= DIFF_SIZE[0];
            mines_q      <= DIFF_MINES[0];
            gen_start_q  <= 1'b0;
            play_en_q    <= 1'b0;
            gen_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_diff_q  <= pend_diff_d;
            pend_vld_q   <= pend_vld_d;
            gen_frames_q <= gen_frames_d;
            size_q       <= size_d;
            mines_q      <= mines_d;
            gen_start_q  <= gen_start_d;
            play_en_q    <= play_en_d;
            gen_err_q    <= gen_err_d;
        end
    end

    game_timer #(
        .FRAMES_PER_SEC(FRAMES_PER_SEC),
        .SEC_MAX       (SEC_MAX)
    ) u_timer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (timer_clear),
        .run_i        (timer_run),
        .frame_start_i(frame_start_i),
        .seconds_o    (seconds_o)
    );

    assign game_state_o = state_q;
    assign gen_start_o  = gen_start_q;
    assign board_size_o = size_q;
    assign mine_count_o = mines_q;
    assign play_en_o    = play_en_q;
    assign gen_err_o    = gen_err_q;

endmodule

// File: tb/tb_game_ctl.sv
// Directed bench for game_ctl: reset, difficulty start, play timer,
// win/lose, generator timeout, mid-play reset and button priority.
module tb_game_ctl;

    localparam logic [2:0] S_MENU = 3'd0;
    localparam logic [2:0] S_GEN  = 3'd1;
    localparam logic [2:0] S_PLAY = 3'd2;
    localparam logic [2:0] S_WIN  = 3'd3;
    localparam logic [2:0] S_LOSE = 3'd4;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] btn_pulse;
    logic       frame_start;
    logic       gen_done;
    logic       mine_hit;
    logic [9:0] revealed_cnt;
    logic       gen_start;
    logic [4:0] board_size;
    logic [6:0] mine_count;
    logic [2:0] game_state;
    logic       play_en;
    logic [9:0] seconds;
    logic       gen_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    game_ctl dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .btn_pulse_i   (btn_pulse),
        .frame_start_i (frame_start),
        .gen_done_i    (gen_done),
        .mine_hit_i    (mine_hit),
        .revealed_cnt_i(revealed_cnt),
        .gen_start_o   (gen_start),
        .board_size_o  (board_size),
        .mine_count_o  (mine_count),
        .game_state_o  (game_state),
        .play_en_o     (play_en),
        .seconds_o     (seconds),
        .gen_err_o     (gen_err)
    );

    // One clock: inputs set before the call are sampled on this edge,
    // outputs are read 1 time unit later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; btn_pulse = 3'd0; frame_start = 1'b0; gen_done = 1'b0;
        mine_hit = 1'b0; revealed_cnt = 10'd0;
        cyc(); cyc();
        rst = 1'b0;
        repeat (5) cyc();
        if (game_state !== S_MENU) begin errors++; $display("FAIL reset_state: got %0d expected %0d", game_state, S_MENU); end checks++;
        if (board_size !== 5'd8) begin errors++; $display("FAIL reset_size: got %0d expected 8", board_size); end checks++;
        if (mine_count !== 7'd10) begin errors++; $display("FAIL reset_mines: got %0d expected 10", mine_count); end checks++;
        if (gen_start !== 1'b0) begin errors++; $display("FAIL reset_gen_start: got %0d expected 0", gen_start); end checks++;
        if (seconds !== 10'd0) begin errors++; $display("FAIL reset_seconds: got %0d expected 0", seconds); end checks++;
        if (play_en !== 1'b0 || gen_err !== 1'b0) begin errors++; $display("FAIL reset_flags: got play_en=%0d gen_err=%0d expected 0 0", play_en, gen_err); end checks++;
        gen_done = 1'b1; cyc(); gen_done = 1'b0;
        if (game_state !== S_MENU) begin errors++; $display("FAIL gen_done_in_menu: got %0d expected %0d", game_state, S_MENU); end checks++;
    endtask

    task automatic test_medium_start();
        btn_pulse = 3'b010; cyc(); btn_pulse = 3'd0;
        repeat (100) cyc();
        if (board_size !== 5'd8 || game_state !== S_MENU) begin errors++; $display("FAIL pend_no_load: got size=%0d state=%0d expected 8 0", board_size, game_state); end checks++;
        frame_start = 1'b1; cyc(); frame_start = 1'b0;
        if (gen_start !== 1'b1) begin errors++; $display("FAIL start_pulse: got %0d expected 1", gen_start); end checks++;
        if (board_size !== 5'd16 || mine_count !== 7'd40) begin errors++; $display("FAIL medium_cfg: got %0d/%0d expected 16/40", board_size, mine_count); end checks++;
        if (game_state !== S_GEN) begin errors++; $display("FAIL enter_gen: got %0d expected %0d", game_state, S_GEN); end checks++;
        cyc();
        if (gen_start !== 1'b0) begin errors++; $display("FAIL start_one_cycle: got %0d expected 0", gen_start); end checks++;
        gen_done = 1'b1; cyc(); gen_done = 1'b0;
        if (game_state !== S_PLAY || play_en !== 1'b1) begin errors++; $display("FAIL enter_play: got state=%0d play_en=%0d expected 2 1", game_state, play_en); end checks++;
    endtask

    task automatic test_timer();
        for (int i = 0; i < 61; i++) begin
            frame_start = 1'b1; cyc(); frame_start = 1'b0; cyc();
        end
        if (seconds !== 10'd1) begin errors++; $display("FAIL timer_61_frames: got %0d expected 1", seconds); end checks++;
        frame_start = 1'b1;
        repeat (60000) cyc();
        frame_start = 1'b0;
        if (seconds !== 10'd999) begin errors++; $display("FAIL timer_saturate: got %0d expected 999", seconds); end checks++;
        if (game_state !== S_PLAY) begin errors++; $display("FAIL still_play: got %0d expected %0d", game_state, S_PLAY); end checks++;
        mine_hit = 1'b1; cyc(); mine_hit = 1'b0;
        if (game_state !== S_LOSE || play_en !== 1'b0) begin errors++; $display("FAIL lose_on_hit: got state=%0d play_en=%0d expected 4 0", game_state, play_en); end checks++;
        if (seconds !== 10'd999) begin errors++; $display("FAIL lose_seconds: got %0d expected 999", seconds); end checks++;
        btn_pulse = 3'b001; cyc(); btn_pulse = 3'd0;
        if (game_state !== S_MENU) begin errors++; $display("FAIL lose_to_menu: got %0d expected %0d", game_state, S_MENU); end checks++;
        frame_start = 1'b1; cyc(); frame_start = 1'b0;
        if (game_state !== S_MENU || gen_start !== 1'b0 || board_size !== 5'd16) begin errors++; $display("FAIL exit_press_no_select: got state=%0d gen_start=%0d size=%0d expected 0 0 16", game_state, gen_start, board_size); end checks++;
    endtask

    task automatic test_win_hard();
        btn_pulse = 3'b100; cyc(); btn_pulse = 3'd0;
        frame_start = 1'b1; cyc(); frame_start = 1'b0;
        if (board_size !== 5'd24 || mine_count !== 7'd99 || seconds !== 10'd0) begin errors++; $display("FAIL hard_cfg: got %0d/%0d sec=%0d expected 24/99 sec=0", board_size, mine_count, seconds); end checks++;
        gen_done = 1'b1; cyc(); gen_done = 1'b0;
        frame_start = 1'b1; repeat (119) cyc(); frame_start = 1'b0;
        if (seconds !== 10'd1) begin errors++; $display("FAIL hard_119_frames: got %0d expected 1", seconds); end checks++;
        revealed_cnt = 10'd476; cyc();
        if (game_state !== S_PLAY) begin errors++; $display("FAIL no_win_476: got %0d expected %0d", game_state, S_PLAY); end checks++;
        revealed_cnt = 10'd477; frame_start = 1'b1; cyc(); frame_start = 1'b0;
        if (game_state !== S_WIN || play_en !== 1'b0) begin errors++; $display("FAIL win_477: got state=%0d play_en=%0d expected 3 0", game_state, play_en); end checks++;
        if (seconds !== 10'd1) begin errors++; $display("FAIL exit_frame_no_tick: got %0d expected 1", seconds); end checks++;
        frame_start = 1'b1; repeat (60) cyc(); frame_start = 1'b0;
        mine_hit = 1'b1; cyc(); mine_hit = 1'b0;
        if (seconds !== 10'd1 || game_state !== S_WIN) begin errors++; $display("FAIL win_frozen: got sec=%0d state=%0d expected 1 3", seconds, game_state); end checks++;
        revealed_cnt = 10'd0;
        btn_pulse = 3'b010; cyc(); btn_pulse = 3'd0;
        frame_start = 1'b1; cyc(); frame_start = 1'b0;
        if (game_state !== S_MENU || board_size !== 5'd24) begin errors++; $display("FAIL win_exit: got state=%0d size=%0d expected 0 24", game_state, board_size); end checks++;
    endtask

    task automatic test_lose_priority();
        btn_pulse = 3'b100; cyc(); btn_pulse = 3'd0;
        frame_start = 1'b1; cyc(); frame_start = 1'b0;
        gen_done = 1'b1; cyc(); gen_done = 1'b0;
        revealed_cnt = 10'd477; mine_hit = 1'b1; cyc(); mine_hit = 1'b0; revealed_cnt = 10'd0;
        if (game_state !== S_LOSE) begin errors++; $display("FAIL lose_beats_win: got %0d expected %0d", game_state, S_LOSE); end checks++;
        btn_pulse = 3'b100; cyc(); btn_pulse = 3'd0;
    endtask

    task automatic test_gen_timeout();
        btn_pulse = 3'b010; cyc(); btn_pulse = 3'd0;
        frame_start = 1'b1; cyc(); frame_start = 1'b0;
        btn_pulse = 3'b100; cyc(); btn_pulse = 3'd0;
        for (int i = 0; i < 3; i++) begin
            frame_start = 1'b1; cyc(); frame_start = 1'b0; cyc();
        end
        if (game_state !== S_GEN || gen_err !== 1'b0) begin errors++; $display("FAIL gen_wait_3: got state=%0d err=%0d expected 1 0", game_state, gen_err); end checks++;
        frame_start = 1'b1; cyc(); frame_start = 1'b0;
        if (game_state !== S_MENU || gen_err !== 1'b1) begin errors++; $display("FAIL gen_timeout: got state=%0d err=%0d expected 0 1", game_state, gen_err); end checks++;
        if (board_size !== 5'd16 || mine_count !== 7'd40) begin errors++; $display("FAIL timeout_keeps_cfg: got %0d/%0d expected 16/40", board_size, mine_count); end checks++;
        frame_start = 1'b1; cyc(); frame_start = 1'b0;
        if (game_state !== S_MENU) begin errors++; $display("FAIL gen_press_ignored: got %0d expected %0d", game_state, S_MENU); end checks++;
        btn_pulse = 3'b001; cyc(); btn_pulse = 3'd0;
        frame_start = 1'b1; cyc(); frame_start = 1'b0;
        if (gen_err !== 1'b0 || board_size !== 5'd8 || game_state !== S_GEN) begin errors++; $display("FAIL restart_clears_err: got err=%0d size=%0d state=%0d expected 0 8 1", gen_err, board_size, game_state); end checks++;
        gen_done = 1'b1; cyc(); gen_done = 1'b0;
    endtask

    task automatic test_reset_mid_play();
        frame_start = 1'b1; repeat (300) cyc(); frame_start = 1'b0;
        if (seconds !== 10'd5 || game_state !== S_PLAY) begin errors++; $display("FAIL play_5s: got sec=%0d state=%0d expected 5 2", seconds, game_state); end checks++;
        rst = 1'b1; cyc(); rst = 1'b0;
        if (game_state !== S_MENU || seconds !== 10'd0 || play_en !== 1'b0) begin errors++; $display("FAIL mid_play_reset: got state=%0d sec=%0d play_en=%0d expected 0 0 0", game_state, seconds, play_en); end checks++;
    endtask

    task automatic test_priority();
        btn_pulse = 3'b110; cyc(); btn_pulse = 3'd0;
        frame_start = 1'b1; cyc(); frame_start = 1'b0;
        if (board_size !== 5'd16 || mine_count !== 7'd40) begin errors++; $display("FAIL prio_bit1_over_bit2: got %0d/%0d expected 16/40", board_size, mine_count); end checks++;
        gen_done = 1'b1; cyc(); gen_done = 1'b0;
        mine_hit = 1'b1; cyc(); mine_hit = 1'b0;
        btn_pulse = 3'b001; cyc();
        btn_pulse = 3'b100; cyc();
        btn_pulse = 3'b101; cyc(); btn_pulse = 3'd0;
        frame_start = 1'b1; cyc(); frame_start = 1'b0;
        if (board_size !== 5'd8 || mine_count !== 7'd10 || game_state !== S_GEN) begin errors++; $display("FAIL prio_bit0_over_bit2: got %0d/%0d state=%0d expected 8/10 1", board_size, mine_count, game_state); end checks++;
    endtask

    initial begin
        test_reset();
        test_medium_start();
        test_timer();
        test_win_hard();
        test_lose_priority();
        test_gen_timeout();
        test_reset_mid_play();
        test_priority();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
